// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_pkg.sv
// Shared ddr2_blk_rdwr packing constants: 8 words of 72 bits carry exactly 9 words of 64 bits.
// Both the 64b-to-72b packer and the 72b-to-64b unpacker use these.
package ddr2_blk_rdwr_fifo_72b_2_64b_pkg;

  localparam int PACK_IN_BYTES     = 9;
  localparam int PACK_OUT_BYTES    = 8;
  localparam int PACK_BLK_WORDS_72 = 8;
  localparam int PACK_BLK_WORDS_64 = 9;

  localparam int IN_W  = 8 * PACK_IN_BYTES;
  localparam int OUT_W = 8 * PACK_OUT_BYTES;

  typedef logic [3:0] res_cnt_t;

  // The residual holds a complete output word when it has this many bytes.
  localparam res_cnt_t RES_FULL = res_cnt_t'(PACK_OUT_BYTES);

endpackage

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head whenever empty is low.
// Writes are dropped when the FIFO is full and no pop happens in the same cycle.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   CNT_DEPTH = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_NEAR  = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = (MAX_DEPTH_BITS + 1)'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      full_int;
  logic                      push;
  logic                      pop;

  always_comb begin
    empty       = (count_q == '0);
    full_int    = (count_q == CNT_DEPTH);
    nearly_full = (count_q >= CNT_NEAR);
    dout        = mem_q[rd_ptr_q];
    pop         = rd_en && !empty;
    push        = wr_en && (!full_int || pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv
// Re-slices a byte-packed stream of 72-bit DDR2 read words into 64-bit words.
// A left-justified residual of up to 8 bytes carries the leftover tail of each input word.
module ddr2_blk_rdwr_fifo_72b_2_64b
  import ddr2_blk_rdwr_fifo_72b_2_64b_pkg::*;
#(
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             flush,
  input  logic             rd_en,
  output logic [OUT_W-1:0] rd_data,
  output logic [OUT_W-1:0] rd_data_d1,
  output logic             empty
);

  logic [IN_W-1:0]  fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd;

  res_cnt_t         res_cnt_q, res_cnt_d;
  logic [OUT_W-1:0] residual_q, residual_d;
  logic [OUT_W-1:0] rd_data_d1_q, rd_data_d1_d;

  logic             res_full;
  logic             pop;
  logic [OUT_W-1:0] rd_word;
  logic [OUT_W-1:0] res_nxt;

  fallthrough_small_fifo #(
    .WIDTH          (IN_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (rst),
    .din         (wr_data),
    .wr_en       (wr_en),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .nearly_full (full),
    .empty       (fifo_empty)
  );

  always_comb begin
    res_full = (res_cnt_q == RES_FULL);
    empty    = !(res_full || !fifo_empty);
    pop      = rd_en && !flush && !empty;
    fifo_rd  = pop && !res_full;

    // Output = top k residual bytes + top (8-k) head bytes; the head's remaining k+1 bytes become the residual.
    rd_word = residual_q;
    res_nxt = '0;
    case (res_cnt_q)
      4'd0: begin rd_word = fifo_dout[71:8];                       res_nxt = {fifo_dout[7:0],  56'h0}; end
      4'd1: begin rd_word = {residual_q[63:56], fifo_dout[71:16]}; res_nxt = {fifo_dout[15:0], 48'h0}; end
      4'd2: begin rd_word = {residual_q[63:48], fifo_dout[71:24]}; res_nxt = {fifo_dout[23:0], 40'h0}; end
      4'd3: begin rd_word = {residual_q[63:40], fifo_dout[71:32]}; res_nxt = {fifo_dout[31:0], 32'h0}; end
      4'd4: begin rd_word = {residual_q[63:32], fifo_dout[71:40]}; res_nxt = {fifo_dout[39:0], 24'h0}; end
      4'd5: begin rd_word = {residual_q[63:24], fifo_dout[71:48]}; res_nxt = {fifo_dout[47:0], 16'h0}; end
      4'd6: begin rd_word = {residual_q[63:16], fifo_dout[71:56]}; res_nxt = {fifo_dout[55:0], 8'h0};  end
      4'd7: begin rd_word = {residual_q[63:8],  fifo_dout[71:64]}; res_nxt = fifo_dout[63:0];          end
      default: begin rd_word = residual_q; res_nxt = '0; end
    endcase

    rd_data = pop ? rd_word : '0;

    res_cnt_d  = res_cnt_q;
    residual_d = residual_q;
    if (flush) begin
      res_cnt_d  = '0;
      residual_d = '0;
    end else if (pop) begin
      if (res_full) begin
        res_cnt_d  = '0;
        residual_d = '0;
      end else begin
        res_cnt_d  = res_cnt_q + 4'd1;
        residual_d = res_nxt;
      end
    end

    rd_data_d1_d = rd_data;
    rd_data_d1   = rd_data_d1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_q    <= '0;
      residual_q   <= '0;
      rd_data_d1_q <= '0;
    end else begin
      res_cnt_q    <= res_cnt_d;
      residual_q   <= residual_d;
      rd_data_d1_q <= rd_data_d1_d;
    end
  end

endmodule

// File: tb/tb_ddr2_blk_rdwr_fifo_72b_2_64b.sv
// Scoreboard bench for the 72b-to-64b unpacker: a byte-stream model produces both the 72-bit
// input words and the expected 64-bit words; a negedge monitor checks every output cycle.
module tb_ddr2_blk_rdwr_fifo_72b_2_64b;
  import ddr2_blk_rdwr_fifo_72b_2_64b_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        full;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] rd_data;
  logic [63:0] rd_data_d1;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  bs[$];
  logic [71:0] wr_q[$];
  logic [63:0] sb[$];

  logic [63:0] mon_exp;
  logic [63:0] prev_exp = '0;
  logic [63:0] exp_d1;
  int          rst_cnt = 0;
  int          last_rst_cnt = 0;

  ddr2_blk_rdwr_fifo_72b_2_64b #(.FIFO_DEPTH_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_data_d1 (rd_data_d1),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  always @(posedge rst) rst_cnt++;

  // Monitor: whenever the DUT presents a word, it must be the scoreboard head; otherwise rd_data is 0.
  always @(negedge clk) begin
    mon_exp = '0;
    if (!rst && rd_en && !flush && !empty) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %h, scoreboard empty", rd_data);
      end else begin
        mon_exp = sb.pop_front();
      end
    end
    vectors++;
    if (rd_data !== mon_exp) begin
      miscompares++;
      $display("FAIL rd_data @%0t: got %h expected %h", $time, rd_data, mon_exp);
    end
    exp_d1 = (rst_cnt != last_rst_cnt) ? 64'h0 : prev_exp;
    last_rst_cnt = rst_cnt;
    vectors++;
    if (rd_data_d1 !== exp_d1) begin
      miscompares++;
      $display("FAIL rd_data_d1 @%0t: got %h expected %h", $time, rd_data_d1, exp_d1);
    end
    prev_exp = rst ? 64'h0 : mon_exp;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_seq(input logic [7:0] base);
    bs.delete();
    for (int i = 0; i < PACK_BLK_WORDS_72 * PACK_IN_BYTES; i++) bs.push_back(base + 8'(i));
  endtask

  task automatic fill_rand(input int n);
    bs.delete();
    for (int i = 0; i < n; i++) bs.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_wr(input int first, input int count);
    logic [71:0] v;
    for (int w = 0; w < count; w++) begin
      v = '0;
      for (int j = 0; j < PACK_IN_BYTES; j++) v = {v[63:0], bs[PACK_IN_BYTES * (first + w) + j]};
      wr_q.push_back(v);
    end
  endtask

  task automatic push_exp_at(input int off, input int count);
    logic [63:0] v;
    for (int w = 0; w < count; w++) begin
      v = '0;
      for (int j = 0; j < PACK_OUT_BYTES; j++) v = {v[55:0], bs[off + PACK_OUT_BYTES * w + j]};
      sb.push_back(v);
    end
  endtask

  task automatic writer();
    int guard = 0;
    while (wr_q.size() > 0) begin
      if (!full) begin
        wr_data = wr_q.pop_front();
        wr_en   = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 400) begin
        vectors++;
        miscompares++;
        $display("FAIL writer_timeout: %0d words left, required 0", wr_q.size());
        wr_q.delete();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic reader(input int budget);
    int n = 0;
    rd_en = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    rd_en = 1'b0;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL reader_timeout: %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_block();
    push_wr(0, PACK_BLK_WORDS_72);
    push_exp_at(0, PACK_BLK_WORDS_64);
    fork
      writer();
      reader(100);
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_empty", empty, 1'b1);
    check("reset_full", full, 1'b0);
    check("reset_rd_data_d1", rd_data_d1, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned block 0x00..0x47
    fill_seq(8'h00);
    run_block();
    check("aligned_empty", empty, 1'b1);
    check("aligned_res_cnt", dut.res_cnt_q, 4'd0);

    // Round trip: 36 random 64-bit words through the packed byte stream
    fill_rand(36 * PACK_OUT_BYTES);
    push_wr(0, 32);
    push_exp_at(0, 36);
    fork
      writer();
      reader(200);
    join
    check("roundtrip_res_cnt", dut.res_cnt_q, 4'd0);

    // Stall: only W0 available, three read cycles
    fill_seq(8'h00);
    push_wr(0, 1);
    writer();
    push_exp_at(0, 1);
    rd_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("stall_empty", empty, 1'b1);
    check("stall_rd_data", rd_data, 64'h0);
    check("stall_res_cnt", dut.res_cnt_q, 4'd1);
    rd_en = 1'b0;
    push_wr(1, 7);
    push_exp_at(8, 8);
    fork
      writer();
      reader(100);
    join
    check("stall_end_res_cnt", dut.res_cnt_q, 4'd0);

    // res_cnt==8 with FIFO empty
    fill_seq(8'h50);
    push_wr(0, 8);
    push_exp_at(0, 8);
    fork
      writer();
      reader(100);
    join
    check("res8_res_cnt", dut.res_cnt_q, 4'd8);
    check("res8_empty", empty, 1'b0);
    check("res8_fifo_empty", dut.fifo_empty, 1'b1);
    push_exp_at(64, 1);
    reader(5);
    check("res8_after_res_cnt", dut.res_cnt_q, 4'd0);
    check("res8_after_empty", empty, 1'b1);

    // Flush mid-block after three pops
    fill_seq(8'h20);
    push_wr(0, 4);
    push_exp_at(0, 3);
    fork
      writer();
      reader(100);
    join
    check("flush_pre_res_cnt", dut.res_cnt_q, 4'd3);
    flush = 1'b1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rd_en = 1'b0;
    check("flush_res_cnt", dut.res_cnt_q, 4'd0);
    check("flush_keeps_fifo", empty, 1'b0);
    push_exp_at(27, 1);
    reader(10);
    check("flush_post_res_cnt", dut.res_cnt_q, 4'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush2_empty", empty, 1'b1);

    // Backpressure: hold wr_en for 6 words into a 4-deep FIFO
    fill_rand(6 * PACK_IN_BYTES);
    push_wr(0, 6);
    for (int i = 0; i < 6; i++) begin
      wr_data = wr_q.pop_front();
      wr_en   = 1'b1;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    check("bp_full", full, 1'b1);
    push_exp_at(0, 4);
    reader(40);
    check("bp_drop_empty", empty, 1'b1);
    check("bp_drop_res_cnt", dut.res_cnt_q, 4'd4);
    check("bp_full_clear", full, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    // Asynchronous reset mid-drain
    fill_seq(8'h10);
    push_wr(0, 3);
    writer();
    push_exp_at(0, 1);
    reader(10);
    #2;
    rst = 1'b1;
    #1;
    check("rst_rd_data_d1", rd_data_d1, 64'h0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_res_cnt", dut.res_cnt_q, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_seq(8'hC0);
    run_block();
    check("post_rst_empty", empty, 1'b1);
    check("post_rst_res_cnt", dut.res_cnt_q, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
